instr_prefetch: RTL and testbench

Instruction prefetch buffer between the instruction memory port and `fetch_stage`. Issues sequential word fetches on a valid/ready request channel, queues in-order responses with their PC in a small FIFO, and presents one instruction per cycle to fetch. On a taken branch from execute it flushes the queue, discards in-flight responses and restarts fetching at the branch target.

---
 rtl/instr_prefetch.sv | 99 +++++++++
 tb/tb_instr_prefetch.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/instr_prefetch.sv
// Instruction prefetch buffer: issues sequential word fetches, queues in-order
// responses with their PC, and hands one instruction per cycle to fetch.
// A taken branch flushes the queue and discards responses still in flight.
module instr_prefetch #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        pf_if_valid,
  output logic [31:0] pf_if_instr_data,
  output logic [31:0] pf_if_pc,
  input  logic        if_pf_ready,
  input  logic        ex_pf_take_branch,
  input  logic [31:0] ex_pf_branch_target
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0]  DEPTH_C = (CW+1)'(DEPTH);
  localparam logic [31:0]  RST_PC  = {RESET_PC[31:2], 2'b00};

  typedef enum logic {FETCH, DRAIN} mode_e;

  logic [31:0]   req_pc, resp_pc;
  logic [31:0]   fifo_instr [DEPTH];
  logic [31:0]   fifo_pc    [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, inflight, drop_cnt;

  mode_e       mode;
  logic [31:0] target;
  logic        credit_ok, req_hs, resp_ok, push, pop;

  assign target    = ex_pf_branch_target & ~32'h3;
  assign mode      = (drop_cnt != '0) ? DRAIN : FETCH;
  // Credits cover both queued entries and requests whose data is still coming,
  // so the FIFO can never overflow.
  assign credit_ok = ({1'b0, count} + {1'b0, inflight}) < DEPTH_C;

  assign imem_req_valid = !rst && !ex_pf_take_branch && credit_ok;
  assign imem_req_addr  = rst ? 32'h0 : req_pc;
  assign req_hs         = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign resp_ok = imem_resp_valid && (inflight != '0);
  assign push    = resp_ok && (mode == FETCH) && !ex_pf_take_branch;

  assign pf_if_valid      = !rst && (count != '0) && !ex_pf_take_branch;
  assign pf_if_instr_data = fifo_instr[rd_ptr];
  assign pf_if_pc         = fifo_pc[rd_ptr];
  assign pop              = pf_if_valid && if_pf_ready;

  // Control state: PCs, FIFO pointers, occupancy and in-flight bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_pc   <= RST_PC;
      resp_pc  <= RST_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      inflight <= '0;
      drop_cnt <= '0;
    end else if (ex_pf_take_branch) begin
      // Everything still outstanding belongs to the wrong path.
      req_pc   <= target;
      resp_pc  <= target;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      inflight <= inflight - CW'(resp_ok);
      drop_cnt <= inflight - CW'(resp_ok);
    end else begin
      if (req_hs) req_pc <= req_pc + 32'd4;
      if (push) begin
        wr_ptr  <= wr_ptr + AW'(1);
        resp_pc <= resp_pc + 32'd4;
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count    <= count + CW'(push) - CW'(pop);
      inflight <= inflight + CW'(req_hs) - CW'(resp_ok);
      if (resp_ok && (mode == DRAIN)) drop_cnt <= drop_cnt - CW'(1);
    end
  end

  // FIFO storage; contents are only meaningful below count, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr[wr_ptr] <= imem_resp_data;
      fifo_pc[wr_ptr]    <= resp_pc;
    end
  end

endmodule

// File: tb/tb_instr_prefetch.sv
// Randomized bench for instr_prefetch: a queue-based memory model with
// in-order variable latency, and a transaction-level FIFO model keyed by the
// address of each request that comes back.
module tb_instr_prefetch;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        pf_if_valid;
  logic [31:0] pf_if_instr_data, pf_if_pc;
  logic        if_pf_ready, ex_pf_take_branch;
  logic [31:0] ex_pf_branch_target;

  always #5 clk = ~clk;

  instr_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .pf_if_valid(pf_if_valid), .pf_if_instr_data(pf_if_instr_data),
    .pf_if_pc(pf_if_pc), .if_pf_ready(if_pf_ready),
    .ex_pf_take_branch(ex_pf_take_branch),
    .ex_pf_branch_target(ex_pf_branch_target)
  );

  typedef struct { logic [31:0] addr; int due; bit drop; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

  pend_t       pend_q[$];
  ent_t        fifo_q[$];
  logic [31:0] exp_req;
  int          cyc, last_due, npops;
  int          checks, errors;

  function automatic logic [31:0] mdat(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = 1'b1; imem_req_ready = 1'b1; imem_resp_valid = 1'b0;
      imem_resp_data = 32'h0; if_pf_ready = 1'b1;
      ex_pf_take_branch = (i == n-1);  // reset must override a redirect
      ex_pf_branch_target = 32'h0000_0F00;
      #1;
      chk("rst_req_valid", imem_req_valid, 0);
      chk("rst_pf_valid", pf_if_valid, 0);
      chk("rst_req_addr", imem_req_addr, 0);
      cyc++;
    end
    pend_q.delete(); fifo_q.delete();
    exp_req = RESET_PC; last_due = cyc;
  endtask

  task automatic run_phase(input int n, input int p_rdy, input int p_ifr, input int p_br,
                           input int lat_lo, input int lat_hi, input int p_spur,
                           input bit fix_tgt, input logic [31:0] tgt);
    for (int i = 0; i < n; i++) begin
      bit br, rdy, ifr, real_resp, exp_rv, exp_pv, hs;
      logic [31:0] t;
      pend_t e;
      @(negedge clk);
      rst = 1'b0;
      rdy = ($urandom_range(0, 99) < p_rdy);
      ifr = ($urandom_range(0, 99) < p_ifr);
      br  = ($urandom_range(0, 99) < p_br);
      t   = fix_tgt ? tgt : ($urandom & 32'h0000_FFFF);
      real_resp = (pend_q.size() != 0) && (pend_q[0].due <= cyc);
      imem_req_ready      = rdy;
      if_pf_ready         = ifr;
      ex_pf_take_branch   = br;
      ex_pf_branch_target = t;
      if (real_resp) begin
        imem_resp_valid = 1'b1; imem_resp_data = mdat(pend_q[0].addr);
      end else if (pend_q.size() == 0 && $urandom_range(0, 99) < p_spur) begin
        imem_resp_valid = 1'b1; imem_resp_data = $urandom;
      end else begin
        imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
      end
      #1;
      exp_rv = !br && (fifo_q.size() + pend_q.size() < DEPTH);
      exp_pv = !br && (fifo_q.size() != 0);
      chk("req_valid", imem_req_valid, exp_rv);
      if (exp_rv) chk("req_addr", imem_req_addr, exp_req);
      chk("pf_valid", pf_if_valid, exp_pv);
      if (exp_pv) begin
        chk("pf_pc", pf_if_pc, fifo_q[0].pc);
        chk("pf_instr", pf_if_instr_data, fifo_q[0].instr);
      end
      // Advance the model to the state after the coming edge.
      hs = exp_rv && rdy;
      if (exp_pv && ifr) begin void'(fifo_q.pop_front()); npops++; end
      if (real_resp) begin
        e = pend_q.pop_front();
        if (!e.drop && !br) fifo_q.push_back('{pc: e.addr, instr: mdat(e.addr)});
      end
      if (br) begin
        fifo_q.delete();
        foreach (pend_q[k]) pend_q[k].drop = 1'b1;
        exp_req = t & ~32'h3;
      end
      if (hs) begin
        int d;
        d = cyc + $urandom_range(lat_lo, lat_hi);
        if (d <= last_due) d = last_due + 1;
        last_due = d;
        pend_q.push_back('{addr: exp_req, due: d, drop: 1'b0});
        exp_req = exp_req + 32'd4;
      end
      cyc++;
    end
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; npops = 0;
    do_reset(3);
    // Streaming with 1-cycle memory, everything ready.
    run_phase(20, 100, 100, 0, 1, 1, 0, 1'b0, 32'h0);
    // Fetch stalled: queue fills and requests stop, then drain.
    run_phase(10, 100, 0, 0, 1, 1, 0, 1'b0, 32'h0);
    run_phase(10, 100, 100, 0, 1, 1, 0, 1'b0, 32'h0);
    // 3-cycle memory, redirect to an unaligned target with requests in flight.
    run_phase(2, 100, 100, 0, 3, 3, 0, 1'b0, 32'h0);
    run_phase(1, 100, 100, 100, 3, 3, 0, 1'b1, 32'h0000_0103);
    run_phase(20, 100, 100, 0, 3, 3, 0, 1'b0, 32'h0);
    // Redirects colliding with responses and pops, back-to-back redirects.
    run_phase(200, 100, 100, 15, 1, 2, 0, 1'b0, 32'h0);
    run_phase(3, 100, 100, 100, 1, 1, 0, 1'b0, 32'h0);
    // Fully random traffic, spurious responses, then a mid-run reset.
    run_phase(1500, 60, 70, 4, 1, 4, 20, 1'b0, 32'h0);
    do_reset(2);
    run_phase(10, 100, 100, 0, 1, 1, 0, 1'b0, 32'h0);
    run_phase(500, 50, 50, 3, 1, 5, 10, 1'b0, 32'h0);
    // Address wrap at the top of memory.
    run_phase(1, 100, 100, 100, 1, 1, 0, 1'b1, 32'hFFFF_FFF5);
    run_phase(20, 100, 100, 0, 1, 2, 0, 1'b0, 32'h0);
    chk("progress", (npops > 500) ? 32'd1 : 32'd0, 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
